// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// default table geometry and a small decode helper.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  localparam int BP_DEFAULT_ENTRIES = 16;
  localparam int BP_DEFAULT_IDX_W   = 4;

  function automatic logic cnt_predicts_taken(input cnt_e c);
    return c[1];
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating direction counter: moves one step toward the outcome,
// holding at strong-not-taken and strong-taken.
module bp_sat_counter2
  import branch_predictor_pkg::*;
(
  input  cnt_e state_i,
  input  logic taken_i,
  output cnt_e state_o
);

  always_comb begin
    state_o = state_i;
    unique case (state_i)
      CNT_SNT: state_o = taken_i ? CNT_WNT : CNT_SNT;
      CNT_WNT: state_o = taken_i ? CNT_WT  : CNT_SNT;
      CNT_WT:  state_o = taken_i ? CNT_ST  : CNT_WNT;
      CNT_ST:  state_o = taken_i ? CNT_ST  : CNT_WT;
      default: state_o = state_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, combinational fetch lookup,
// execute-stage update/mispredict detection and saturating statistics counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BP_DEFAULT_ENTRIES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchE,
  input  logic        BranchTakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [15:0] BranchCount,
  output logic [15:0] MispredCount
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  cnt_e             cnt_q    [ENTRIES];
  cnt_e             cnt_d    [ENTRIES];

  logic [15:0] branch_count_q, branch_count_d;
  logic [15:0] mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  cnt_e             cnt_next_e;

  logic unused_pc_low;
  assign unused_pc_low = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
  assign PredTakenF  = hit_f && cnt_predicts_taken(cnt_q[idx_f]);
  assign PredTargetF = PredTakenF ? target_q[idx_f] : (PCF + 32'd4);

  assign MispredictE = BranchE &&
                       ((BranchTakenE != PredTakenE) ||
                        (BranchTakenE && PredTakenE && (PredTargetE != BranchTargetE)));
  assign RedirectPCE = BranchTakenE ? BranchTargetE : (PCE + 32'd4);

  bp_sat_counter2 u_sat_counter (
    .state_i (cnt_q[idx_e]),
    .taken_i (BranchTakenE),
    .state_o (cnt_next_e)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (BranchE) begin
      if (hit_e) begin
        cnt_d[idx_e] = cnt_next_e;
        if (BranchTakenE) target_d[idx_e] = BranchTargetE;
      end else if (BranchTakenE) begin
        // Taken miss evicts whatever aliased into this slot.
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = BranchTargetE;
        cnt_d[idx_e]    = CNT_WT;
      end
    end
  end

  always_comb begin
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (BranchE && (branch_count_q != 16'hFFFF))
      branch_count_d = branch_count_q + 16'd1;
    if (MispredictE && (mispred_count_q != 16'hFFFF))
      mispred_count_d = mispred_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      target_q        <= target_d;
      cnt_q           <= cnt_d;
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign BranchCount  = branch_count_q;
  assign MispredCount = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchE;
  logic        BranchTakenE;
  logic [31:0] PCE;
  logic [31:0] BranchTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [15:0] BranchCount;
  logic [15:0] MispredCount;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .PCF           (PCF),
    .PredTakenF    (PredTakenF),
    .PredTargetF   (PredTargetF),
    .BranchE       (BranchE),
    .BranchTakenE  (BranchTakenE),
    .PCE           (PCE),
    .BranchTargetE (BranchTargetE),
    .PredTakenE    (PredTakenE),
    .PredTargetE   (PredTargetE),
    .MispredictE   (MispredictE),
    .RedirectPCE   (RedirectPCE),
    .BranchCount   (BranchCount),
    .MispredCount  (MispredCount)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic taken, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic ptaken, input logic [31:0] ptgt);
    BranchE = 1'b1; BranchTakenE = taken; PCE = pc; BranchTargetE = tgt;
    PredTakenE = ptaken; PredTargetE = ptgt;
  endtask

  task automatic idle();
    BranchE = 1'b0; BranchTakenE = 1'b0; PredTakenE = 1'b0;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; PCF = 32'h40;
    resolve(1'b1, 32'h80, 32'h400, 1'b0, 32'h84);
    tick(); tick();
    reset = 1'b0; idle();
    #1;
    chk1 ("reset_pred_taken", PredTakenF, 1'b0);
    chk32("reset_pred_target", PredTargetF, 32'h44);
    chk32("reset_branch_count", {16'h0, BranchCount}, 32'h0);
    chk32("reset_mispred_count", {16'h0, MispredCount}, 32'h0);
    PCF = 32'h80; #1;
    chk1 ("reset_ignores_branch", PredTakenF, 1'b0);
    chk32("reset_ignores_branch_tgt", PredTargetF, 32'h84);
  endtask

  task automatic test_allocation();
    resolve(1'b1, 32'h100, 32'h200, 1'b0, 32'h104);
    #1;
    chk1 ("alloc_mispredict", MispredictE, 1'b1);
    chk32("alloc_redirect", RedirectPCE, 32'h200);
    tick(); idle(); PCF = 32'h100; #1;
    chk1 ("alloc_pred_taken", PredTakenF, 1'b1);
    chk32("alloc_pred_target", PredTargetF, 32'h200);
    chk32("alloc_branch_count", {16'h0, BranchCount}, 32'd1);
    chk32("alloc_mispred_count", {16'h0, MispredCount}, 32'd1);
  endtask

  task automatic test_hysteresis();
    // 10 -> 11 with a correctly predicted taken branch
    resolve(1'b1, 32'h100, 32'h200, 1'b1, 32'h200); #1;
    chk1("hyst_correct_no_mispred", MispredictE, 1'b0);
    tick();
    resolve(1'b0, 32'h100, 32'h200, 1'b1, 32'h200); #1;
    chk1 ("hyst_nt1_mispred", MispredictE, 1'b1);
    chk32("hyst_nt1_redirect", RedirectPCE, 32'h104);
    tick(); idle(); #1;
    chk1("hyst_after_nt1_taken", PredTakenF, 1'b1);
    resolve(1'b0, 32'h100, 32'h200, 1'b1, 32'h200);
    tick(); idle(); #1;
    chk1 ("hyst_after_nt2_taken", PredTakenF, 1'b0);
    chk32("hyst_after_nt2_target", PredTargetF, 32'h104);
    resolve(1'b0, 32'h100, 32'h200, 1'b0, 32'h104); #1;
    chk1("hyst_nt3_no_mispred", MispredictE, 1'b0);
    tick();
    // From 00 a single taken reaches only 01, still predicting not-taken
    resolve(1'b1, 32'h100, 32'h200, 1'b0, 32'h104);
    tick(); idle(); #1;
    chk1("hyst_sat_low", PredTakenF, 1'b0);
    chk32("hyst_branch_count", {16'h0, BranchCount}, 32'd6);
    chk32("hyst_mispred_count", {16'h0, MispredCount}, 32'd4);
  endtask

  task automatic test_aliasing();
    resolve(1'b1, 32'h100, 32'h200, 1'b0, 32'h104);
    tick(); idle(); PCF = 32'h100; #1;
    chk1("alias_pre_hit", PredTakenF, 1'b1);
    resolve(1'b1, 32'h140, 32'h500, 1'b0, 32'h144);
    tick();
    // Not-taken miss at the same index must not disturb the table
    resolve(1'b0, 32'h180, 32'h600, 1'b0, 32'h184);
    tick(); idle(); PCF = 32'h100; #1;
    chk1 ("alias_old_miss", PredTakenF, 1'b0);
    chk32("alias_old_target", PredTargetF, 32'h104);
    PCF = 32'h140; #1;
    chk1 ("alias_new_hit", PredTakenF, 1'b1);
    chk32("alias_new_target", PredTargetF, 32'h500);
    PCF = 32'h180; #1;
    chk1("alias_nt_no_alloc", PredTakenF, 1'b0);
  endtask

  task automatic test_collision();
    resolve(1'b1, 32'h104, 32'h200, 1'b0, 32'h108);
    tick();
    PCF = 32'h104;
    resolve(1'b1, 32'h104, 32'h300, 1'b1, 32'h200); #1;
    chk1 ("coll_mispredict", MispredictE, 1'b1);
    chk32("coll_redirect", RedirectPCE, 32'h300);
    chk1 ("coll_same_cycle_taken", PredTakenF, 1'b1);
    chk32("coll_same_cycle_target", PredTargetF, 32'h200);
    tick(); idle(); #1;
    chk32("coll_next_cycle_target", PredTargetF, 32'h300);
    PCE = 32'h104; BranchTargetE = 32'h300; BranchTakenE = 1'b0; #1;
    chk32("redirect_without_branch", RedirectPCE, 32'h108);
    chk1 ("no_branch_no_mispred", MispredictE, 1'b0);
    BranchTakenE = 1'b1; PredTakenE = 1'b0; #1;
    chk1 ("no_branch_no_mispred_t", MispredictE, 1'b0);
    chk32("redirect_taken_no_branch", RedirectPCE, 32'h300);
    BranchTakenE = 1'b0;
    PCF = 32'hFFFF_FFFC; #1;
    chk32("pc_plus4_wrap", PredTargetF, 32'h0);
  endtask

  task automatic test_saturation();
    idle(); reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk32("sat_reset_count", {16'h0, BranchCount}, 32'h0);
    resolve(1'b1, 32'h100, 32'h200, 1'b0, 32'h104);
    repeat (65534) @(posedge clk);
    #1;
    chk32("sat_branch_fffe", {16'h0, BranchCount}, 32'hFFFE);
    chk32("sat_mispred_fffe", {16'h0, MispredCount}, 32'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    idle();
    chk32("sat_branch_ffff", {16'h0, BranchCount}, 32'hFFFF);
    chk32("sat_mispred_ffff", {16'h0, MispredCount}, 32'hFFFF);
    tick();
    chk32("sat_hold_branch", {16'h0, BranchCount}, 32'hFFFF);
  endtask

  initial begin
    reset = 1'b1; PCF = '0; PCE = '0; BranchTargetE = '0; PredTargetE = '0;
    idle();
    test_reset();
    test_allocation();
    test_hysteresis();
    test_aliasing();
    test_collision();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped predictor entries (power of two, 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port PCF  input  32  fetch-stage PC being looked up.
REQ-005 SHALL have port PredTakenF  output  1  fetch-stage prediction: redirect fetch to PredTargetF.
REQ-006 SHALL have port PredTargetF  output  32  predicted next PC: BTB target if PredTakenF, else PCF+4.
REQ-007 SHALL have port BranchE  input  1  a conditional-branch instruction resolves in execute this cycle, already condition-evaluated and not flushed.
REQ-008 SHALL have port BranchTakenE  input  1  actual outcome of the resolving branch.
REQ-009 SHALL have port PCE  input  32  PC of the resolving branch.
REQ-010 SHALL have port BranchTargetE  input  32  actual target of the resolving branch.
REQ-011 SHALL have port PredTakenE  input  1  PredTakenF carried down the pipeline with that branch.
REQ-012 SHALL have port PredTargetE  input  32  PredTargetF carried down the pipeline with that branch.
REQ-013 SHALL have port MispredictE  output  1  resolving branch was mispredicted; feeds FlushD/FlushE.
REQ-014 SHALL have port RedirectPCE  output  32  correct next PC after the resolving branch.
REQ-015 SHALL have port BranchCount  output  16  number of resolved branches, saturating.
REQ-016 SHALL have port MispredCount  output  16  number of mispredictions, saturating.

Function
REQ-017 SHALL, for each entry, hold valid (1 b), tag PC[31:2+log2(ENTRIES)], target (32 b) and a 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-018 SHALL index with PC[1+log2(ENTRIES):2]; hit = valid and tag equal.
REQ-019 SHALL compute lookup combinationally: PredTakenF = hit and counter[1]; PredTargetF = PredTakenF ? target : PCF+4 (mod 2^32).
REQ-020 SHALL, on BranchE with hit at PCE, move the counter toward the outcome by one, saturating at 00 and 11, and rewrite target with BranchTargetE when BranchTakenE.
REQ-021 SHALL, on BranchE with miss and BranchTakenE, allocate the entry: valid=1, tag from PCE, target=BranchTargetE, counter=10; the previous occupant is overwritten.
REQ-022 SHALL, on BranchE with miss and not BranchTakenE, leave the table unchanged.
REQ-023 SHALL assert MispredictE combinationally when BranchE and (BranchTakenE != PredTakenE, or both taken and PredTargetE != BranchTargetE); MispredictE = 0 when BranchE = 0.
REQ-024 SHALL drive RedirectPCE = BranchTakenE ? BranchTargetE : PCE+4, regardless of BranchE.
REQ-025 SHALL give read-before-write on an index collision: lookup in the same cycle as an update returns pre-update contents; the update is visible the next cycle.
REQ-026 SHALL increment BranchCount on each BranchE and MispredCount on each MispredictE, each holding at 0xFFFF.
REQ-027 SHALL have table-update latency of exactly one cycle and no other pipeline state.

Reset
REQ-028 SHALL, while reset is high at a clock edge, clear all valid bits, set all counters to 01, zero target/tag, and zero BranchCount and MispredCount; a BranchE in that cycle is ignored.
REQ-029 SHALL, after reset, give PredTakenF = 0 and PredTargetF = PCF+4 for every PCF until an allocation occurs.

Structure
REQ-030 SHALL place the counter encodings (SNT/WNT/WT/ST) and the default index width in a shared package used by the pipeline.
REQ-031 SHALL implement counter update in one sub-module, bp_sat_counter2 (current state, taken -> next state, purely combinational).

Verification
REQ-032 SHALL cover reset: after reset, PCF=0x00000040 -> PredTakenF=0, PredTargetF=0x00000044; both counts = 0.
REQ-033 SHALL cover allocation: BranchE, taken, PCE=0x100, target 0x200, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x200; next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x200.
REQ-034 SHALL cover hysteresis: entry at 11, two not-taken resolutions -> first leaves PredTakenF=1 (10), second gives 0 (01); third not-taken saturates at 00.
REQ-035 SHALL cover aliasing: PCE=0x100 allocated, then taken branch at 0x140 (same index, ENTRIES=16) -> lookup 0x100 misses, 0x140 hits.
REQ-036 SHALL cover target mismatch and collision: predicted taken to 0x200, actual taken to 0x300 -> MispredictE=1, RedirectPCE=0x300; same-cycle lookup of the PC returns 0x200, next cycle 0x300.
REQ-037 SHALL cover saturation: 65 540 mispredicting resolutions -> MispredCount = BranchCount = 0xFFFF.
